// File: rtl/id_ex_stage.sv
// id_ex_stage: ID/EX pipeline register with load-use hazard detection,
// branch flush and global hold, plus saturating stall/flush event counters.
//
// Ports:
//   clk, rst (sync, active-high), hold (freeze), flush_EX (squash entry)
//   *_ID      : decoded instruction fields from ID (uses_rs*_ID not registered)
//   *_IDEX    : registered copies of the ID fields (all zero = bubble)
//   PCWrite, IFIDWrite : combinational enables for PC and IF/ID
//   load_use_stall     : a load-use bubble is being inserted this cycle
//   stall_cnt, flush_cnt : saturating event counters
module id_ex_stage (
  input  logic        clk,
  input  logic        rst,
  input  logic        hold,
  input  logic        flush_EX,
  input  logic        valid_ID,
  input  logic [31:0] pc_ID,
  input  logic [31:0] rs1_data_ID,
  input  logic [31:0] rs2_data_ID,
  input  logic [31:0] imm_ID,
  input  logic [4:0]  rs1_ID,
  input  logic [4:0]  rs2_ID,
  input  logic [4:0]  rd_ID,
  input  logic        uses_rs1_ID,
  input  logic        uses_rs2_ID,
  input  logic        RegWrite_ID,
  input  logic        MemRead_ID,
  input  logic        MemWrite_ID,
  input  logic        MemToReg_ID,
  input  logic        ALUSrc_ID,
  input  logic        Branch_ID,
  input  logic [3:0]  ALUCtrl_ID,
  output logic        valid_IDEX,
  output logic [31:0] pc_IDEX,
  output logic [31:0] rs1_data_IDEX,
  output logic [31:0] rs2_data_IDEX,
  output logic [31:0] imm_IDEX,
  output logic [4:0]  rs1_IDEX,
  output logic [4:0]  rs2_IDEX,
  output logic [4:0]  rd_IDEX,
  output logic        RegWrite_IDEX,
  output logic        MemRead_IDEX,
  output logic        MemWrite_IDEX,
  output logic        MemToReg_IDEX,
  output logic        ALUSrc_IDEX,
  output logic        Branch_IDEX,
  output logic [3:0]  ALUCtrl_IDEX,
  output logic        PCWrite,
  output logic        IFIDWrite,
  output logic        load_use_stall,
  output logic [15:0] stall_cnt,
  output logic [15:0] flush_cnt
);

  typedef struct packed {
    logic        valid;
    logic [31:0] pc;
    logic [31:0] rs1_data;
    logic [31:0] rs2_data;
    logic [31:0] imm;
    logic [4:0]  rs1;
    logic [4:0]  rs2;
    logic [4:0]  rd;
    logic        reg_write;
    logic        mem_read;
    logic        mem_write;
    logic        mem_to_reg;
    logic        alu_src;
    logic        branch;
    logic [3:0]  alu_ctrl;
  } idex_t;

  idex_t       id_in;
  idex_t       idex_q, idex_d;
  logic [15:0] stall_cnt_q, stall_cnt_d;
  logic [15:0] flush_cnt_q, flush_cnt_d;
  logic        load_use;

  assign id_in = {valid_ID, pc_ID, rs1_data_ID, rs2_data_ID, imm_ID,
                  rs1_ID, rs2_ID, rd_ID, RegWrite_ID, MemRead_ID,
                  MemWrite_ID, MemToReg_ID, ALUSrc_ID, Branch_ID, ALUCtrl_ID};

  // A load in EX whose destination is read by the valid instruction in ID.
  // x0 is never a real dependency.
  always_comb begin
    load_use = idex_q.valid & idex_q.mem_read & (idex_q.rd != 5'd0) & valid_ID &
               ((uses_rs1_ID & (rs1_ID == idex_q.rd)) |
                (uses_rs2_ID & (rs2_ID == idex_q.rd)));
    // A flush already squashes the dependent path; hold freezes everything.
    load_use_stall = load_use & ~hold & ~flush_EX;
    PCWrite        = ~(hold | load_use_stall);
    IFIDWrite      = ~(hold | load_use_stall);
  end

  always_comb begin
    idex_d      = idex_q;
    stall_cnt_d = stall_cnt_q;
    flush_cnt_d = flush_cnt_q;
    if (hold) begin
      idex_d = idex_q;
    end else if (flush_EX) begin
      idex_d      = '0;
      flush_cnt_d = (flush_cnt_q == 16'hFFFF) ? flush_cnt_q : flush_cnt_q + 16'd1;
    end else if (load_use_stall) begin
      idex_d      = '0;
      stall_cnt_d = (stall_cnt_q == 16'hFFFF) ? stall_cnt_q : stall_cnt_q + 16'd1;
    end else begin
      idex_d = id_in;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      idex_q      <= '0;
      stall_cnt_q <= '0;
      flush_cnt_q <= '0;
    end else begin
      idex_q      <= idex_d;
      stall_cnt_q <= stall_cnt_d;
      flush_cnt_q <= flush_cnt_d;
    end
  end

  assign valid_IDEX    = idex_q.valid;
  assign pc_IDEX       = idex_q.pc;
  assign rs1_data_IDEX = idex_q.rs1_data;
  assign rs2_data_IDEX = idex_q.rs2_data;
  assign imm_IDEX      = idex_q.imm;
  assign rs1_IDEX      = idex_q.rs1;
  assign rs2_IDEX      = idex_q.rs2;
  assign rd_IDEX       = idex_q.rd;
  assign RegWrite_IDEX = idex_q.reg_write;
  assign MemRead_IDEX  = idex_q.mem_read;
  assign MemWrite_IDEX = idex_q.mem_write;
  assign MemToReg_IDEX = idex_q.mem_to_reg;
  assign ALUSrc_IDEX   = idex_q.alu_src;
  assign Branch_IDEX   = idex_q.branch;
  assign ALUCtrl_IDEX  = idex_q.alu_ctrl;
  assign stall_cnt     = stall_cnt_q;
  assign flush_cnt     = flush_cnt_q;

endmodule

// File: tb/tb_id_ex_stage.sv
module tb_id_ex_stage;

  typedef struct packed {
    logic        valid;
    logic [31:0] pc;
    logic [31:0] d1;
    logic [31:0] d2;
    logic [31:0] imm;
    logic [4:0]  rs1;
    logic [4:0]  rs2;
    logic [4:0]  rd;
    logic        rw;
    logic        mr;
    logic        mw;
    logic        m2r;
    logic        as;
    logic        br;
    logic [3:0]  alu;
  } idex_t;

  typedef struct {
    bit          r, h, f, valid, mr, u1;
    logic [4:0]  rs1, rd;
    logic [31:0] pc;
    bit          elus, epcw, ev;
    logic [4:0]  ers1;
    logic [31:0] epc;
    int          es, ef;
  } vec_t;

  logic clk = 1'b0;
  logic rst, hold, flush_EX, uses1, uses2;
  idex_t din;
  idex_t act;

  logic        valid_IDEX, RegWrite_IDEX, MemRead_IDEX, MemWrite_IDEX;
  logic        MemToReg_IDEX, ALUSrc_IDEX, Branch_IDEX;
  logic [31:0] pc_IDEX, rs1_data_IDEX, rs2_data_IDEX, imm_IDEX;
  logic [4:0]  rs1_IDEX, rs2_IDEX, rd_IDEX;
  logic [3:0]  ALUCtrl_IDEX;
  logic        PCWrite, IFIDWrite, load_use_stall;
  logic [15:0] stall_cnt, flush_cnt;

  int passed = 0;
  int total  = 0;

  always #5 clk = ~clk;

  id_ex_stage dut (
    .clk(clk), .rst(rst), .hold(hold), .flush_EX(flush_EX),
    .valid_ID(din.valid), .pc_ID(din.pc), .rs1_data_ID(din.d1),
    .rs2_data_ID(din.d2), .imm_ID(din.imm), .rs1_ID(din.rs1),
    .rs2_ID(din.rs2), .rd_ID(din.rd), .uses_rs1_ID(uses1), .uses_rs2_ID(uses2),
    .RegWrite_ID(din.rw), .MemRead_ID(din.mr), .MemWrite_ID(din.mw),
    .MemToReg_ID(din.m2r), .ALUSrc_ID(din.as), .Branch_ID(din.br),
    .ALUCtrl_ID(din.alu),
    .valid_IDEX(valid_IDEX), .pc_IDEX(pc_IDEX), .rs1_data_IDEX(rs1_data_IDEX),
    .rs2_data_IDEX(rs2_data_IDEX), .imm_IDEX(imm_IDEX), .rs1_IDEX(rs1_IDEX),
    .rs2_IDEX(rs2_IDEX), .rd_IDEX(rd_IDEX), .RegWrite_IDEX(RegWrite_IDEX),
    .MemRead_IDEX(MemRead_IDEX), .MemWrite_IDEX(MemWrite_IDEX),
    .MemToReg_IDEX(MemToReg_IDEX), .ALUSrc_IDEX(ALUSrc_IDEX),
    .Branch_IDEX(Branch_IDEX), .ALUCtrl_IDEX(ALUCtrl_IDEX),
    .PCWrite(PCWrite), .IFIDWrite(IFIDWrite), .load_use_stall(load_use_stall),
    .stall_cnt(stall_cnt), .flush_cnt(flush_cnt)
  );

  assign act = {valid_IDEX, pc_IDEX, rs1_data_IDEX, rs2_data_IDEX, imm_IDEX,
                rs1_IDEX, rs2_IDEX, rd_IDEX, RegWrite_IDEX, MemRead_IDEX,
                MemWrite_IDEX, MemToReg_IDEX, ALUSrc_IDEX, Branch_IDEX, ALUCtrl_IDEX};

  task automatic check(input string name, input logic [159:0] a, input logic [159:0] e);
    total++;
    if (a === e) passed++;
    else $display("FAIL %s: got %0h expected %0h", name, a, e);
  endtask

  // Drive one cycle's inputs away from the rising edge.
  task automatic drive(input idex_t d, input logic u1, input logic u2,
                       input logic r, input logic h, input logic f);
    @(negedge clk);
    din = d; uses1 = u1; uses2 = u2; rst = r; hold = h; flush_EX = f;
    #1;
  endtask

  task automatic post_edge();
    @(posedge clk);
    #1;
  endtask

  function automatic vec_t mk(bit r, bit h, bit f, bit v, bit mr, bit u1,
                              logic [4:0] rs1, logic [4:0] rd, logic [31:0] pc,
                              bit elus, bit epcw, bit ev, logic [4:0] ers1,
                              logic [31:0] epc, int es, int ef);
    vec_t t;
    t.r = r; t.h = h; t.f = f; t.valid = v; t.mr = mr; t.u1 = u1;
    t.rs1 = rs1; t.rd = rd; t.pc = pc; t.elus = elus; t.epcw = epcw;
    t.ev = ev; t.ers1 = ers1; t.epc = epc; t.es = es; t.ef = ef;
    return t;
  endfunction

  vec_t  vt[$];
  idex_t exp_q;
  int    exp_sc, exp_fc;

  initial begin
    idex_t d;
    logic  lu, elus, epcw;
    logic  r, h, f, u1, u2;

    din = '0; uses1 = 0; uses2 = 0; rst = 1; hold = 0; flush_EX = 0;

    // Reset with hold and flush asserted must still clear everything.
    drive('0, 0, 0, 1, 1, 1);
    post_edge();
    check("reset_idex", act, '0);
    check("reset_stall_cnt", stall_cnt, 0);
    check("reset_flush_cnt", flush_cnt, 0);

    //      r h f v mr u1 rs1 rd  pc      lus pcw ev ers1 epc    sc fc
    vt.push_back(mk(0,0,0,1,1,1, 1, 5, 'h100, 0,1, 1, 1, 'h100, 0,0)); // lw x5
    vt.push_back(mk(0,0,0,1,0,1, 5, 6, 'h104, 1,0, 0, 0, 'h0,   1,0)); // add uses x5: bubble
    vt.push_back(mk(0,0,0,1,0,1, 5, 6, 'h104, 0,1, 1, 5, 'h104, 1,0)); // add re-enters
    vt.push_back(mk(0,0,0,1,1,1, 2, 7, 'h108, 0,1, 1, 2, 'h108, 1,0)); // lw x7
    vt.push_back(mk(0,0,0,1,0,0, 7, 8, 'h10c, 0,1, 1, 7, 'h10c, 1,0)); // rs1 not used
    vt.push_back(mk(0,0,0,1,1,1, 3, 0, 'h110, 0,1, 1, 3, 'h110, 1,0)); // lw x0
    vt.push_back(mk(0,0,0,1,0,1, 0, 9, 'h114, 0,1, 1, 0, 'h114, 1,0)); // x0 no stall
    vt.push_back(mk(0,0,0,1,1,1, 4, 5, 'h118, 0,1, 1, 4, 'h118, 1,0)); // lw x5
    vt.push_back(mk(0,0,1,1,0,1, 5, 6, 'h11c, 0,1, 0, 0, 'h0,   1,1)); // flush beats stall
    vt.push_back(mk(0,0,0,1,1,1, 4, 5, 'h120, 0,1, 1, 4, 'h120, 1,1)); // lw x5
    vt.push_back(mk(0,1,1,1,0,1, 5, 6, 'h200, 0,0, 1, 4, 'h120, 1,1)); // hold x3
    vt.push_back(mk(0,1,1,1,0,1, 5, 6, 'h204, 0,0, 1, 4, 'h120, 1,1));
    vt.push_back(mk(0,1,1,1,0,1, 5, 6, 'h208, 0,0, 1, 4, 'h120, 1,1));
    vt.push_back(mk(0,0,1,1,0,1, 5, 6, 'h20c, 0,1, 0, 0, 'h0,   1,2)); // hold drops, flush
    vt.push_back(mk(0,0,0,1,1,1, 6, 5, 'h300, 0,1, 1, 6, 'h300, 1,2)); // lw x5
    vt.push_back(mk(1,1,0,1,0,1, 5, 6, 'h304, 0,0, 0, 0, 'h0,   0,0)); // reset during hold
    vt.push_back(mk(0,0,0,1,1,1, 6, 5, 'h400, 0,1, 1, 6, 'h400, 0,0)); // lw x5
    vt.push_back(mk(1,0,0,1,0,1, 5, 6, 'h404, 1,0, 0, 0, 'h0,   0,0)); // reset mid-stall
    vt.push_back(mk(0,0,0,1,0,1, 5, 6, 'h404, 0,1, 1, 5, 'h404, 0,0));

    foreach (vt[i]) begin
      d = '0;
      d.valid = vt[i].valid; d.mr = vt[i].mr; d.rs1 = vt[i].rs1;
      d.rd = vt[i].rd; d.pc = vt[i].pc; d.rw = ~vt[i].mr;
      drive(d, vt[i].u1, 0, vt[i].r, vt[i].h, vt[i].f);
      check($sformatf("vec%0d_load_use_stall", i), load_use_stall, vt[i].elus);
      check($sformatf("vec%0d_PCWrite", i), PCWrite, vt[i].epcw);
      check($sformatf("vec%0d_IFIDWrite", i), IFIDWrite, vt[i].epcw);
      post_edge();
      check($sformatf("vec%0d_valid", i), valid_IDEX, vt[i].ev);
      check($sformatf("vec%0d_rs1", i), rs1_IDEX, vt[i].ers1);
      check($sformatf("vec%0d_pc", i), pc_IDEX, vt[i].epc);
      check($sformatf("vec%0d_stall_cnt", i), stall_cnt, vt[i].es);
      check($sformatf("vec%0d_flush_cnt", i), flush_cnt, vt[i].ef);
      if (!vt[i].ev) check($sformatf("vec%0d_bubble", i), act, '0);
    end

    // Randomized traffic against a reference model. Register indices are
    // drawn from a small range so hazards occur often.
    drive('0, 0, 0, 1, 0, 0);
    post_edge();
    exp_q = '0; exp_sc = 0; exp_fc = 0;
    for (int n = 0; n < 3000; n++) begin
      d = idex_t'({$urandom, $urandom, $urandom, $urandom, $urandom});
      d.rs1 = 5'($urandom_range(0, 3));
      d.rs2 = 5'($urandom_range(0, 3));
      d.rd  = 5'($urandom_range(0, 3));
      d.mr  = ($urandom_range(0, 2) == 0);
      u1 = $urandom_range(0, 1); u2 = $urandom_range(0, 1);
      r  = ($urandom_range(0, 63) == 0);
      h  = ($urandom_range(0, 7) == 0);
      f  = ($urandom_range(0, 7) == 0);
      drive(d, u1, u2, r, h, f);

      lu = exp_q.valid && exp_q.mr && exp_q.rd != 0 && d.valid &&
           ((u1 && d.rs1 == exp_q.rd) || (u2 && d.rs2 == exp_q.rd));
      elus = lu && !h && !f;
      epcw = !(h || elus);
      check("rand_load_use_stall", load_use_stall, elus);
      check("rand_PCWrite", PCWrite, epcw);
      check("rand_IFIDWrite", IFIDWrite, epcw);

      if (r) begin
        exp_q = '0; exp_sc = 0; exp_fc = 0;
      end else if (h) begin
        // nothing changes
      end else if (f) begin
        exp_q = '0; exp_fc = (exp_fc < 65535) ? exp_fc + 1 : 65535;
      end else if (elus) begin
        exp_q = '0; exp_sc = (exp_sc < 65535) ? exp_sc + 1 : 65535;
      end else begin
        exp_q = d;
      end
      post_edge();
      check("rand_idex", act, exp_q);
      check("rand_stall_cnt", stall_cnt, exp_sc);
      check("rand_flush_cnt", flush_cnt, exp_fc);
    end

    // Flush counter saturation.
    drive('0, 0, 0, 1, 0, 0);
    post_edge();
    @(negedge clk);
    rst = 0; flush_EX = 1;
    repeat (65535) @(posedge clk);
    #1;
    check("sat_flush_cnt_full", flush_cnt, 16'hFFFF);
    check("sat_stall_cnt", stall_cnt, 0);
    post_edge();
    check("sat_flush_cnt_stays", flush_cnt, 16'hFFFF);
    check("sat_bubble", act, '0);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
